spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 39 +++
 rtl/spi_slave.sv | 150 +++++++++++++++
 tb/tb_spi_slave.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave bundle: system-side byte handshake plus the four SPI pins.
// Ports (slave view):
//   in  : i_TX_DV, i_TX_Byte[7:0], i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI
//   out : o_RX_DV, o_RX_Byte[7:0], o_TX_Ready, o_SPI_MISO
interface spi_slave_if;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Ready;
    logic       i_SPI_Clk;
    logic       i_SPI_CS_n;
    logic       i_SPI_MOSI;
    logic       o_SPI_MISO;

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        input  i_SPI_Clk,
        input  i_SPI_CS_n,
        input  i_SPI_MOSI,
        output o_RX_DV,
        output o_RX_Byte,
        output o_TX_Ready,
        output o_SPI_MISO
    );

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        output i_SPI_Clk,
        output i_SPI_CS_n,
        output i_SPI_MOSI,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_TX_Ready,
        input  o_SPI_MISO
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, modes 0..3, oversampling SCK/CS/MOSI on the system clock.
// Ports: i_Clk, i_Rst_L (async, active low), spi (spi_slave_if.slave).
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while idle or in reset.
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    spi_slave_if.slave  spi
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state;
    logic [2:0] sck_s;
    logic [2:0] cs_s;
    logic [1:0] mosi_s;
    logic [6:0] rx_shift;
    logic [2:0] rx_cnt;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic [7:0] hold;
    logic       hold_full;
    logic       tx_ready;
    logic [7:0] tx_shift;
    logic [2:0] tx_cnt;
    logic       miso_q;

    logic       sck_lead;
    logic       sck_trail;
    logic       cs_fall;
    logic       cs_rise;
    logic       samp_edge;
    logic       shift_edge;
    logic       tx_accept;
    logic       load_tx;
    logic [7:0] tx_next;

    // Stage 1 of each synchronizer is metastability guard; stage 2 is the
    // synchronized value and stage 3 its one-cycle-old copy.
    always_comb begin
        sck_lead   = (sck_s[1] != CPOL) && (sck_s[2] == CPOL);
        sck_trail  = (sck_s[1] == CPOL) && (sck_s[2] != CPOL);
        cs_fall    = !cs_s[1] && cs_s[2];
        cs_rise    = cs_s[1] && !cs_s[2];
        samp_edge  = CPHA ? sck_trail : sck_lead;
        shift_edge = CPHA ? sck_lead : sck_trail;
        tx_accept  = spi.i_TX_DV && tx_ready;
        tx_next    = hold_full ? hold : 8'hFF;
        load_tx    = 1'b0;
        if (state == IDLE) begin
            load_tx = cs_fall;
        end else begin
            load_tx = !cs_rise && shift_edge && (tx_cnt == 3'd0);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_s     <= {3{CPOL}};
            cs_s      <= 3'b111;
            mosi_s    <= 2'b00;
            state     <= IDLE;
            rx_shift  <= 7'd0;
            rx_cnt    <= 3'd7;
            rx_byte   <= 8'h00;
            rx_dv     <= 1'b0;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            tx_ready  <= 1'b0;
            tx_shift  <= 8'hFF;
            tx_cnt    <= 3'd7;
            miso_q    <= 1'b1;
        end else begin
            sck_s  <= {sck_s[1:0], spi.i_SPI_Clk};
            cs_s   <= {cs_s[1:0], spi.i_SPI_CS_n};
            mosi_s <= {mosi_s[0], spi.i_SPI_MOSI};
            rx_dv  <= 1'b0;

            // A transfer empties the holding register; a same-cycle accept
            // refills it for the following byte.
            if (tx_accept) begin
                hold      <= spi.i_TX_Byte;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end else if (load_tx) begin
                hold_full <= 1'b0;
                tx_ready  <= 1'b1;
            end else begin
                tx_ready  <= !hold_full;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        rx_cnt   <= 3'd7;
                        tx_cnt   <= 3'd7;
                        tx_shift <= tx_next;
                        miso_q   <= tx_next[7];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state  <= IDLE;
                        rx_cnt <= 3'd7;
                        tx_cnt <= 3'd7;
                    end else begin
                        if (samp_edge) begin
                            rx_shift <= {rx_shift[5:0], mosi_s[1]};
                            if (rx_cnt == 3'd0) begin
                                rx_byte <= {rx_shift, mosi_s[1]};
                                rx_dv   <= 1'b1;
                                rx_cnt  <= 3'd7;
                            end else begin
                                rx_cnt <= rx_cnt - 3'd1;
                            end
                        end
                        // CPHA=1 presents bit tx_cnt on the leading edge;
                        // CPHA=0 already shows it and moves to the next one.
                        if (shift_edge) begin
                            if (tx_cnt == 3'd0) begin
                                tx_shift <= tx_next;
                                tx_cnt   <= 3'd7;
                                miso_q   <= CPHA ? tx_shift[0] : tx_next[7];
                            end else begin
                                tx_cnt <= tx_cnt - 3'd1;
                                miso_q <= CPHA ? tx_shift[tx_cnt]
                                               : tx_shift[tx_cnt - 3'd1];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi.o_RX_DV    = rx_dv;
    assign spi.o_RX_Byte  = rx_byte;
    assign spi.o_TX_Ready = tx_ready;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign spi.o_SPI_MISO = (state == ACTIVE) ? miso_q : 1'bz;
`else
    assign spi.o_SPI_MISO = (state == ACTIVE) ? miso_q : 1'b1;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: a mode-0 and a mode-3 spi_slave driven by a bit-banged
// SPI master; expected bytes are hand-computed constants.
module tb_spi_slave;
    localparam time H = 60ns;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b1;
`endif

    logic            clk;
    logic            rst_n;
    logic [1:0]      sck;
    logic [1:0]      csn;
    logic [1:0]      tx_dv;
    logic [1:0][7:0] txb;
    logic            mosi;

    int         n_run;
    int         n_fail;
    int         dv_n [2];
    logic [7:0] last_rx [2];
    logic [7:0] rxq3 [$];

    spi_slave_if if0 ();
    spi_slave_if if3 ();

    assign if0.i_SPI_Clk  = sck[0];
    assign if0.i_SPI_CS_n = csn[0];
    assign if0.i_SPI_MOSI = mosi;
    assign if0.i_TX_DV    = tx_dv[0];
    assign if0.i_TX_Byte  = txb[0];
    assign if3.i_SPI_Clk  = sck[1];
    assign if3.i_SPI_CS_n = csn[1];
    assign if3.i_SPI_MOSI = mosi;
    assign if3.i_TX_DV    = tx_dv[1];
    assign if3.i_TX_Byte  = txb[1];

    wire [1:0] miso  = {if3.o_SPI_MISO, if0.o_SPI_MISO};
    wire [1:0] ready = {if3.o_TX_Ready, if0.o_TX_Ready};

    spi_slave #(.SPI_MODE(0)) u_m0 (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .spi     (if0.slave)
    );

    spi_slave #(.SPI_MODE(3)) u_m3 (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .spi     (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if0.o_RX_DV === 1'b1) begin
            dv_n[0]++;
            last_rx[0] = if0.o_RX_Byte;
        end
        if (if3.o_RX_DV === 1'b1) begin
            dv_n[1]++;
            last_rx[1] = if3.o_RX_Byte;
            rxq3.push_back(if3.o_RX_Byte);
        end
    end

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // d: 0 selects the mode-0 slave, 1 the mode-3 slave
    task automatic load(input int d, input logic [7:0] b);
        @(negedge clk);
        tx_dv[d] = 1'b1;
        txb[d]   = b;
        @(negedge clk);
        tx_dv[d] = 1'b0;
    endtask

    task automatic cs_lo(input int d);
        csn[d] = 1'b0;
        #100ns;
    endtask

    task automatic cs_hi(input int d);
        #H;
        csn[d] = 1'b1;
        #100ns;
    endtask

    task automatic spi_byte(input int d, input logic [7:0] tx, input int nb,
                            output logic [7:0] rx);
        logic cp;
        cp = (d == 1);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!cp) begin
                mosi   = tx[i];
                #H;
                sck[d] = ~cp;
                rx[i]  = miso[d];
                #H;
                sck[d] = cp;
            end else begin
                sck[d] = ~cp;
                mosi   = tx[i];
                #H;
                sck[d] = cp;
                rx[i]  = miso[d];
                #H;
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] r1;
        logic [7:0] r2;
        int         n;
        n_run   = 0;
        n_fail  = 0;
        dv_n    = '{0, 0};
        last_rx = '{8'h00, 8'h00};
        rst_n   = 1'b0;
        sck     = 2'b10;
        csn     = 2'b11;
        tx_dv   = 2'b00;
        txb     = '0;
        mosi    = 1'b0;

        #33ns;
        check("rst_ready0", {7'd0, ready[0]}, 8'h00);
        check("rst_rxbyte0", if0.o_RX_Byte, 8'h00);
        check("rst_dv0", {7'd0, if0.o_RX_DV}, 8'h00);
        check("rst_miso0", {7'd0, miso[0]}, {7'd0, MISO_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready0", {7'd0, ready[0]}, 8'h01);
        check("rel_ready3", {7'd0, ready[1]}, 8'h01);
        check("idle_miso3", {7'd0, miso[1]}, {7'd0, MISO_IDLE});

        // mode 0: A5 in, 3C out
        load(0, 8'h3C);
        check("m0_ready_lo", {7'd0, ready[0]}, 8'h00);
        n = dv_n[0];
        cs_lo(0);
        check("m0_ready_hi", {7'd0, ready[0]}, 8'h01);
        spi_byte(0, 8'hA5, 8, r);
        cs_hi(0);
        check("m0_miso", r, 8'h3C);
        check("m0_dv_cnt", 8'(dv_n[0] - n), 8'd1);
        check("m0_rx", last_rx[0], 8'hA5);

        // mode 3: three bytes in one frame
        load(1, 8'h11);
        cs_lo(1);
        load(1, 8'h22);
        spi_byte(1, 8'h01, 8, r);
        spi_byte(1, 8'h80, 8, r1);
        spi_byte(1, 8'hFF, 8, r2);
        cs_hi(1);
        check("m3_miso0", r, 8'h11);
        check("m3_miso1", r1, 8'h22);
        check("m3_miso2", r2, 8'hFF);
        check("m3_dv_cnt", 8'(rxq3.size()), 8'd3);
        for (int i = 0; i < rxq3.size() && i < 3; i++) begin
            logic [7:0] e;
            e = (i == 0) ? 8'h01 : (i == 1) ? 8'h80 : 8'hFF;
            check($sformatf("m3_rx%0d", i), rxq3[i], e);
        end

        // abort after 5 bits, then a full frame
        n = dv_n[0];
        cs_lo(0);
        spi_byte(0, 8'hC3, 5, r);
        cs_hi(0);
        check("ab_dv_cnt", 8'(dv_n[0] - n), 8'd0);
        check("ab_rx_keep", if0.o_RX_Byte, 8'hA5);
        cs_lo(0);
        spi_byte(0, 8'h5A, 8, r);
        cs_hi(0);
        check("ab_dv_next", 8'(dv_n[0] - n), 8'd1);
        check("ab_rx_next", if0.o_RX_Byte, 8'h5A);
        check("ab_miso_ff", r, 8'hFF);

        // handshake: second load while not ready is dropped
        load(0, 8'h77);
        check("hs_ready_lo", {7'd0, ready[0]}, 8'h00);
        load(0, 8'h88);
        check("hs_ready_lo2", {7'd0, ready[0]}, 8'h00);
        cs_lo(0);
        spi_byte(0, 8'h00, 8, r);
        cs_hi(0);
        check("hs_miso", r, 8'h77);

        // reset mid-byte
        n = dv_n[0];
        cs_lo(0);
        spi_byte(0, 8'hF0, 4, r);
        #3ns;
        rst_n = 1'b0;
        #1ns;
        check("mr_dv", {7'd0, if0.o_RX_DV}, 8'h00);
        check("mr_rx", if0.o_RX_Byte, 8'h00);
        check("mr_ready", {7'd0, ready[0]}, 8'h00);
        check("mr_miso", {7'd0, miso[0]}, {7'd0, MISO_IDLE});
        csn[0] = 1'b1;
        sck[0] = 1'b0;
        #50ns;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr_ready_rel", {7'd0, ready[0]}, 8'h01);
        #100ns;
        check("mr_no_dv", 8'(dv_n[0] - n), 8'd0);
        cs_lo(0);
        spi_byte(0, 8'h3C, 8, r);
        cs_hi(0);
        check("mr_rx_after", if0.o_RX_Byte, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
